// File: rtl/si_regshifter_nave.sv
// Player-ship position register: one-hot bus moved one column per press, with hold-to-repeat.
// Optional one-hot integrity check enabled by defining SI_REGSHIFTER_NAVE_ONEHOT_CHECK_EN.
module si_regshifter_nave #(
    parameter int                     DATAWIDTH_BUS = 8,
    parameter logic [DATAWIDTH_BUS-1:0] START_POS   = 8'b00010000,
    parameter int                     CNT_WIDTH     = 24,
    parameter int                     REPEAT_DELAY  = 12500000,
    parameter int                     REPEAT_PERIOD = 5000000
) (
    input  logic                     SI_REGSHIFTER_NAVE_CLOCK_50,
    input  logic                     SI_REGSHIFTER_NAVE_RESET_InHigh,
    input  logic                     SI_REGSHIFTER_NAVE_CLEAR,
    input  logic                     SI_REGSHIFTER_NAVE_LEFT,
    input  logic                     SI_REGSHIFTER_NAVE_RIGHT,
    input  logic [1:0]               SI_REGSHIFTER_NAVE_IND_BUS,
    output logic [DATAWIDTH_BUS-1:0] SI_REGSHIFTER_NAVE_BUS_OUT,
    output logic                     SI_REGSHIFTER_NAVE_MOVING,
    output logic                     SI_REGSHIFTER_NAVE_EDGE_HIT,
    output logic                     SI_REGSHIFTER_NAVE_ERROR
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_t;

    state_t                 state;
    dir_t                   dir_q;
    dir_t                   dir_req;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [DATAWIDTH_BUS-1:0] step_bus;
    logic                   step_blocked;

    localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

    // Both buttons held counts as no request, so it also aborts a running repeat.
    always_comb begin
        dir_req = DIR_NONE;
        if (SI_REGSHIFTER_NAVE_LEFT && !SI_REGSHIFTER_NAVE_RIGHT)
            dir_req = DIR_L;
        else if (SI_REGSHIFTER_NAVE_RIGHT && !SI_REGSHIFTER_NAVE_LEFT)
            dir_req = DIR_R;
    end

    always_comb begin
        step_bus     = SI_REGSHIFTER_NAVE_BUS_OUT;
        step_blocked = 1'b0;
        case (dir_req)
            DIR_L: begin
                if (SI_REGSHIFTER_NAVE_IND_BUS[1]) step_bus = SI_REGSHIFTER_NAVE_BUS_OUT << 1;
                else                               step_blocked = 1'b1;
            end
            DIR_R: begin
                if (SI_REGSHIFTER_NAVE_IND_BUS[0]) step_bus = SI_REGSHIFTER_NAVE_BUS_OUT >> 1;
                else                               step_blocked = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SI_REGSHIFTER_NAVE_ONEHOT_CHECK_EN
    logic onehot_ok;
    assign onehot_ok = (SI_REGSHIFTER_NAVE_BUS_OUT != '0) &&
                       ((SI_REGSHIFTER_NAVE_BUS_OUT &
                         (SI_REGSHIFTER_NAVE_BUS_OUT - DATAWIDTH_BUS'(1))) == '0);
`endif

    always_ff @(posedge SI_REGSHIFTER_NAVE_CLOCK_50 or posedge SI_REGSHIFTER_NAVE_RESET_InHigh) begin
        if (SI_REGSHIFTER_NAVE_RESET_InHigh) begin
            SI_REGSHIFTER_NAVE_BUS_OUT  <= START_POS;
            SI_REGSHIFTER_NAVE_MOVING   <= 1'b0;
            SI_REGSHIFTER_NAVE_EDGE_HIT <= 1'b0;
`ifdef SI_REGSHIFTER_NAVE_ONEHOT_CHECK_EN
            SI_REGSHIFTER_NAVE_ERROR    <= 1'b0;
`endif
            state <= IDLE;
            dir_q <= DIR_NONE;
            cnt   <= '0;
        end else begin
            SI_REGSHIFTER_NAVE_EDGE_HIT <= 1'b0;
`ifdef SI_REGSHIFTER_NAVE_ONEHOT_CHECK_EN
            SI_REGSHIFTER_NAVE_ERROR    <= 1'b0;
`endif
            if (SI_REGSHIFTER_NAVE_CLEAR) begin
                SI_REGSHIFTER_NAVE_BUS_OUT <= START_POS;
                SI_REGSHIFTER_NAVE_MOVING  <= 1'b0;
                state <= IDLE;
                cnt   <= '0;
`ifdef SI_REGSHIFTER_NAVE_ONEHOT_CHECK_EN
            end else if (!onehot_ok) begin
                SI_REGSHIFTER_NAVE_BUS_OUT <= START_POS;
                SI_REGSHIFTER_NAVE_MOVING  <= 1'b0;
                SI_REGSHIFTER_NAVE_ERROR   <= 1'b1;
                state <= IDLE;
                cnt   <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (dir_req != DIR_NONE) begin
                            SI_REGSHIFTER_NAVE_BUS_OUT  <= step_bus;
                            SI_REGSHIFTER_NAVE_EDGE_HIT <= step_blocked;
                            SI_REGSHIFTER_NAVE_MOVING   <= 1'b1;
                            dir_q <= dir_req;
                            cnt   <= '0;
                            state <= DELAY;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (dir_req == dir_q) begin
                            // Compare the pre-increment count so steps land exactly on the delay/period edge.
                            if (cnt == ((state == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                                SI_REGSHIFTER_NAVE_BUS_OUT  <= step_bus;
                                SI_REGSHIFTER_NAVE_EDGE_HIT <= step_blocked;
                                cnt   <= '0;
                                state <= REPEAT;
                            end else begin
                                cnt <= cnt + CNT_WIDTH'(1);
                            end
                        end else begin
                            SI_REGSHIFTER_NAVE_MOVING <= 1'b0;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        SI_REGSHIFTER_NAVE_MOVING <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifndef SI_REGSHIFTER_NAVE_ONEHOT_CHECK_EN
    assign SI_REGSHIFTER_NAVE_ERROR = 1'b0;
`endif

endmodule
